lomo_frame_receiver: RTL

- Deserializer for the telemetry serial link (MK frame marker, CLK bit clock, DAT data).
- Sits directly downstream of the frame generator.
- Oversamples the three lines in the system clock domain and rebuilds 16-bit words MSB-first.
- Tracks group and frame position, checks header words, and presents words with a valid strobe to the capture/logging logic.

---
 rtl/lomo_frame_receiver_if.sv | 42 ++++
 rtl/lomo_frame_receiver.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lomo_frame_receiver_if.sv
// Telemetry link bundle: serial lines MK/CLK/DAT in, reassembled word stream out.
// hdr_err is present only when LOMO_HDR_CHECK_EN is defined.
`timescale 1ns/1ps
interface lomo_frame_receiver_if;
  logic        MK;
  logic        CLK;
  logic        DAT;
  logic [15:0] word_data;
  logic        word_valid;
  logic [3:0]  word_idx;
  logic [5:0]  grp_num;
  logic        frame_start;
  logic        locked;
  logic        sync_err;
  logic [7:0]  err_cnt;
`ifdef LOMO_HDR_CHECK_EN
  logic        hdr_err;

  // master drives the serial link and consumes words; slave is the receiver
  modport master (
    output MK, CLK, DAT,
    input  word_data, word_valid, word_idx, grp_num, frame_start,
    input  locked, sync_err, err_cnt, hdr_err
  );
  modport slave (
    input  MK, CLK, DAT,
    output word_data, word_valid, word_idx, grp_num, frame_start,
    output locked, sync_err, err_cnt, hdr_err
  );
`else
  modport master (
    output MK, CLK, DAT,
    input  word_data, word_valid, word_idx, grp_num, frame_start,
    input  locked, sync_err, err_cnt
  );
  modport slave (
    input  MK, CLK, DAT,
    output word_data, word_valid, word_idx, grp_num, frame_start,
    output locked, sync_err, err_cnt
  );
`endif
endinterface

// File: rtl/lomo_frame_receiver.sv
// Oversampling deserializer for the MK/CLK/DAT telemetry link with group/frame tracking.
// Optional header checking is built only when LOMO_HDR_CHECK_EN is defined.
`timescale 1ns/1ps
module lomo_frame_receiver #(
  parameter int SYNC_STAGES  = 3,
  parameter int GROUP_WORDS  = 10,
  parameter int FRAME_GROUPS = 64,
  parameter int TIMEOUT      = 4096
) (
  input  logic                  clk,
  input  logic                  reset,
  lomo_frame_receiver_if.slave  io_bus
);

  localparam int              TO_W      = $clog2(TIMEOUT + 1);
  localparam logic [3:0]      LAST_WORD = 4'(GROUP_WORDS - 1);
  localparam logic [5:0]      LAST_GRP  = 6'(FRAME_GROUPS - 1);
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT - 1);

  typedef enum logic {HUNT = 1'b0, LOCK = 1'b1} state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic              w_locked;

  logic [2:0]        w_line_raw;
  logic [2:0]        w_line_sync;
  logic              w_mk;
  logic              w_clk;
  logic              w_dat;
  logic              r_clk_prev;
  logic              w_fall;
  logic              w_edge;

  logic [TO_W-1:0]   r_to_cnt;
  logic              w_timeout;

  logic [15:0]       r_shift;
  logic [15:0]       w_shift_next;
  logic [3:0]        r_bit_cnt;
  logic [3:0]        r_pos_word;
  logic [5:0]        r_pos_grp;
  logic              w_at_start;
  logic              w_acquire;
  logic              w_resync;
  logic              w_word_done;
  logic              w_err_inc;

  logic [15:0]       r_word_data;
  logic              r_word_valid;
  logic [3:0]        r_word_idx;
  logic [5:0]        r_grp_num;
  logic              r_frame_start;
  logic              r_sync_err;
  logic [7:0]        r_err_cnt;

  // Line order inside the synchronizer bank: [2]=MK, [1]=CLK, [0]=DAT
  assign w_line_raw = {io_bus.MK, io_bus.CLK, io_bus.DAT};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_sync
      logic [SYNC_STAGES-1:0] r_sync;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_sync <= '0;
        end else begin
          r_sync <= {r_sync[SYNC_STAGES-2:0], w_line_raw[gi]};
        end
      end
      assign w_line_sync[gi] = r_sync[SYNC_STAGES-1];
    end
  endgenerate

  assign w_dat = w_line_sync[0];
  assign w_clk = w_line_sync[1];
  assign w_mk  = w_line_sync[2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_clk_prev <= 1'b0;
    end else begin
      r_clk_prev <= w_clk;
    end
  end

  assign w_fall = r_clk_prev & ~w_clk;
  assign w_edge = r_clk_prev ^ w_clk;

  // Inactivity counter; only meaningful while locked, saturates at its terminal value
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_to_cnt <= '0;
    end else if ((r_state == HUNT) || w_edge) begin
      r_to_cnt <= '0;
    end else if (r_to_cnt != TO_LAST) begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  assign w_timeout    = (r_state == LOCK) && !w_edge && (r_to_cnt == TO_LAST);
  assign w_shift_next = {r_shift[14:0], w_dat};
  assign w_at_start   = (r_bit_cnt == 4'd15) && (r_pos_word == 4'd0) && (r_pos_grp == 6'd0);
  assign w_acquire    = (r_state == HUNT) && w_fall && w_mk;
  assign w_resync     = (r_state == LOCK) && w_fall && w_mk && !w_at_start;
  assign w_word_done  = (r_state == LOCK) && w_fall && !w_resync && (r_bit_cnt == 4'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= HUNT;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      HUNT:    if (w_acquire) w_state_next = LOCK;
      LOCK:    if (w_timeout) w_state_next = HUNT;
      default: w_state_next = HUNT;
    endcase
  end

  always_comb begin
    w_locked = 1'b0;
    case (r_state)
      LOCK:    w_locked = 1'b1;
      default: w_locked = 1'b0;
    endcase
  end

  // Bit assembly and position tracking; a marker bit always becomes bit 15 of word 0 / group 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shift    <= '0;
      r_bit_cnt  <= 4'd15;
      r_pos_word <= '0;
      r_pos_grp  <= '0;
    end else if (r_state == HUNT) begin
      r_pos_word <= '0;
      r_pos_grp  <= '0;
      if (w_acquire) begin
        r_shift   <= w_shift_next;
        r_bit_cnt <= 4'd14;
      end else begin
        r_bit_cnt <= 4'd15;
      end
    end else if (w_timeout) begin
      r_bit_cnt  <= 4'd15;
      r_pos_word <= '0;
      r_pos_grp  <= '0;
    end else if (w_fall) begin
      r_shift <= w_shift_next;
      if (w_resync) begin
        r_bit_cnt  <= 4'd14;
        r_pos_word <= '0;
        r_pos_grp  <= '0;
      end else if (r_bit_cnt == 4'd0) begin
        r_bit_cnt <= 4'd15;
        if (r_pos_word == LAST_WORD) begin
          r_pos_word <= '0;
          r_pos_grp  <= (r_pos_grp == LAST_GRP) ? 6'd0 : r_pos_grp + 6'd1;
        end else begin
          r_pos_word <= r_pos_word + 4'd1;
        end
      end else begin
        r_bit_cnt <= r_bit_cnt - 4'd1;
      end
    end
  end

`ifdef LOMO_HDR_CHECK_EN
  logic [8:0] r_exp_frm;
  logic       r_frm_loaded;
  logic       r_hdr_err;
  logic       w_hdr_word;
  logic       w_hdr_mismatch;
  logic       w_grp_wrap;

  assign w_hdr_word     = w_word_done && (r_pos_word == 4'd0);
  assign w_grp_wrap     = w_word_done && (r_pos_word == LAST_WORD) && (r_pos_grp == LAST_GRP);
  // Header layout {frm[8:0], grp[5:0], half}; the first header after lock only seeds r_exp_frm
  assign w_hdr_mismatch = w_hdr_word && r_frm_loaded &&
                          ((w_shift_next[6:1]  != r_pos_grp)    ||
                           (w_shift_next[0]    != r_pos_grp[0]) ||
                           (w_shift_next[15:7] != r_exp_frm));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_exp_frm    <= '0;
      r_frm_loaded <= 1'b0;
      r_hdr_err    <= 1'b0;
    end else begin
      r_hdr_err <= w_hdr_mismatch;
      if (r_state == HUNT) begin
        r_frm_loaded <= 1'b0;
      end else if (w_hdr_word && (!r_frm_loaded || w_hdr_mismatch)) begin
        r_exp_frm    <= w_shift_next[15:7];
        r_frm_loaded <= 1'b1;
      end else if (w_grp_wrap) begin
        r_exp_frm <= r_exp_frm + 9'd1;
      end
    end
  end

  assign w_err_inc      = w_resync | w_hdr_mismatch;
  assign io_bus.hdr_err = r_hdr_err;
`else
  assign w_err_inc = w_resync;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_word_data   <= '0;
      r_word_valid  <= 1'b0;
      r_word_idx    <= '0;
      r_grp_num     <= '0;
      r_frame_start <= 1'b0;
      r_sync_err    <= 1'b0;
      r_err_cnt     <= '0;
    end else begin
      r_word_valid  <= w_word_done;
      r_frame_start <= w_word_done && (r_pos_word == 4'd0) && (r_pos_grp == 6'd0);
      r_sync_err    <= w_resync;
      if (w_word_done) begin
        r_word_data <= w_shift_next;
        r_word_idx  <= r_pos_word;
        r_grp_num   <= r_pos_grp;
      end
      // Simultaneous error sources still count once
      if (w_err_inc && (r_err_cnt != 8'hFF)) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end
    end
  end

  assign io_bus.word_data   = r_word_data;
  assign io_bus.word_valid  = r_word_valid;
  assign io_bus.word_idx    = r_word_idx;
  assign io_bus.grp_num     = r_grp_num;
  assign io_bus.frame_start = r_frame_start;
  assign io_bus.locked      = w_locked;
  assign io_bus.sync_err    = r_sync_err;
  assign io_bus.err_cnt     = r_err_cnt;

endmodule
